// File: rtl/dfp_pkg.sv
// dfp_pkg: shared debug codes, drain FSM states and
// the FIFO entry layout for the front panel capture.
package dfp_pkg;

  localparam logic [7:0] SOR      = 8'h00;
  localparam logic [7:0] SENTINEL = 8'h0f;
  localparam logic [7:0] PRINTA   = 8'h10;
  localparam logic [7:0] PRINTLO  = 8'h1c;
  localparam logic [7:0] HALT     = 8'h1d;
  localparam logic [7:0] SUCCESS  = 8'h1e;
  localparam logic [7:0] FAIL     = 8'h1f;

  localparam int FRAME_BYTES = 3;
  localparam logic [1:0] LAST_IDX = 2'(FRAME_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAITLO
  } state_e;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } entry_t;

  function automatic logic [7:0] frame_byte(
    input entry_t     e,
    input logic [1:0] idx
  );
    case (idx)
      2'd0:    frame_byte = e.addr;
      2'd1:    frame_byte = e.data[15:8];
      default: frame_byte = e.data[7:0];
    endcase
  endfunction

endpackage

// File: rtl/dfp_wcap_fifo.sv
// dfp_wcap_fifo: generic synchronous FIFO.
// Ports: clk_i, rst_i (sync high), push_i/pop_i,
// wdata_i, rdata_o (head), rdata_nxt_o (entry behind
// head), full_o, empty_o, level_o (occupancy).
// A push while full is accepted only with a pop.
module dfp_wcap_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter int W     = 24
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic [W-1:0]  rdata_nxt_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   LVL_ONE = (AW+1)'(1);
  localparam logic [AW:0]   LVL_MAX = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   level_q, level_d;
  logic          do_push, do_pop;

  assign full_o  = (level_q == LVL_MAX);
  assign empty_o = (level_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop) level_d = level_q + LVL_ONE;
    if (do_pop && !do_push) level_d = level_q - LVL_ONE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_ONE;
      if (do_pop)  rd_q <= rd_q + PTR_ONE;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o     = mem_q[rd_q];
  assign rdata_nxt_o = mem_q[rd_q + PTR_ONE];
  assign level_o     = level_q;

endmodule

// File: rtl/dfp_wcap.sv
// dfp_wcap: captures I/O 1xx writes, queues {addr,data}
// and drains them as 3-byte frames on fpd with a
// four-phase fpd_stb/fpd_ack handshake.
// Ports: clk4, reset (sync high), nw, niodev1xx, ab, db
// in; fpd, fpd_stb out; fpd_ack in; nhalt_drv, ovf,
// level out. Macro DFP_WCAP_STALL_EN adds nws_drv.
import dfp_pkg::*;

module dfp_wcap #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk4,
  input  logic          reset,
  input  logic          nw,
  input  logic          niodev1xx,
  input  logic [7:0]    ab,
  input  logic [15:0]   db,
  output logic [7:0]    fpd,
  output logic          fpd_stb,
  input  logic          fpd_ack,
  output logic          nhalt_drv,
  output logic          ovf,
  output logic [AW:0]   level
`ifdef DFP_WCAP_STALL_EN
  ,
  output logic          nws_drv
`endif
);

  localparam int W = $bits(entry_t);

  logic        nw_q, niodev_q;
  logic [7:0]  ab_q;
  logic [15:0] db_q;

  state_e      state_q;
  logic [1:0]  idx_q;
  entry_t      cur_q;
  logic [7:0]  fpd_q;
  logic        stb_q, nhalt_q, ovf_q;

  entry_t      wentry, head, head_nxt;
  logic        ev, push, pop, full, empty, more;
  logic [AW:0] lvl;

  // Event fires on the rising edge of nw, so the
  // payload is what was on the bus while nw was low.
  assign ev     = !nw_q && nw && !niodev_q;
  assign push   = ev;
  assign wentry = {ab_q, db_q};
  assign pop    = (state_q == WAITLO) && !fpd_ack &&
                  (idx_q == LAST_IDX);
  assign more   = (lvl > (AW+1)'(1));

  dfp_wcap_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (W)
  ) u_fifo (
    .clk_i       (clk4),
    .rst_i       (reset),
    .push_i      (push),
    .pop_i       (pop),
    .wdata_i     (wentry),
    .rdata_o     (head),
    .rdata_nxt_o (head_nxt),
    .full_o      (full),
    .empty_o     (empty),
    .level_o     (lvl)
  );

  always_ff @(posedge clk4) begin
    if (reset) begin
      nw_q     <= 1'b1;
      niodev_q <= 1'b1;
      ab_q     <= '0;
      db_q     <= '0;
      state_q  <= IDLE;
      idx_q    <= '0;
      cur_q    <= '0;
      fpd_q    <= '0;
      stb_q    <= 1'b0;
      nhalt_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      nw_q     <= nw;
      niodev_q <= niodev1xx;
      ab_q     <= ab;
      db_q     <= db;
      if (ev && (ab_q == HALT || ab_q == SENTINEL))
        nhalt_q <= 1'b0;
      if (push && full && !pop)
        ovf_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (!empty) begin
            cur_q   <= head;
            fpd_q   <= head.addr;
            stb_q   <= 1'b1;
            idx_q   <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (fpd_ack) begin
            stb_q   <= 1'b0;
            state_q <= WAITLO;
          end
        end
        WAITLO: begin
          if (!fpd_ack) begin
            if (idx_q != LAST_IDX) begin
              idx_q   <= idx_q + 2'd1;
              fpd_q   <= frame_byte(cur_q, idx_q + 2'd1);
              stb_q   <= 1'b1;
              state_q <= SEND;
            end else if (more) begin
              // Head is being popped; the next frame
              // starts from the entry behind it.
              cur_q   <= head_nxt;
              fpd_q   <= head_nxt.addr;
              stb_q   <= 1'b1;
              idx_q   <= '0;
              state_q <= SEND;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fpd       = fpd_q;
  assign fpd_stb   = stb_q;
  assign nhalt_drv = nhalt_q;
  assign ovf       = ovf_q;
  assign level     = lvl;

`ifdef DFP_WCAP_STALL_EN
  // Stretch the bus write while only one slot is left.
  assign nws_drv = !((lvl >= (AW+1)'(DEPTH - 1)) &&
                     !niodev1xx);
`endif

endmodule
